// File: rtl/seg7_scan_display_16b.sv
// rtl/seg7_scan_display_16b.sv - four-digit multiplexed hex display with stretched ripple-carry LED
module seg7_scan_display_16b #(
    parameter int SCAN_DIV_BITS  = 17,
    parameter int STRETCH_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
    input  logic        rc_in,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        rc_led
);

    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

    logic [SCAN_DIV_BITS-1:0] div_cnt;
    logic [1:0]               idx;
    logic                     scan_tick;

    logic [15:0]              sh_hex;
    logic [3:0]               sh_points;
    logic [3:0]               sh_les;

    logic [3:0]               nibble;
    logic                     blank;
    logic                     dp_on;
    logic [3:0]               an_next;
    logic [7:0]               seg_next;

    logic [STRETCH_W-1:0]     stretch_cnt;
    logic                     rc_prev;
    logic                     rc_rise;

    function automatic logic [6:0] hex_font(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        return glyph;
    endfunction

    assign scan_tick = &div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_cnt + SCAN_DIV_BITS'(1);
            if (scan_tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Shadow loads only at the end of the last digit slot so a frame never mixes two input values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_hex    <= '0;
            sh_points <= '0;
            sh_les    <= '0;
        end else if (scan_tick && (idx == 2'd3)) begin
            sh_hex    <= hexs;
            sh_points <= points;
            sh_les    <= LEs;
        end
    end

    always_comb begin
        nibble   = sh_hex[{idx, 2'b00} +: 4];
        blank    = sh_les[idx];
        dp_on    = sh_points[idx] & ~blank;
        an_next  = 4'b1111;
        seg_next = 8'hFF;
        if (!blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = {~dp_on, hex_font(nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN      <= 4'b1111;
            SEGMENT <= 8'hFF;
        end else begin
            AN      <= an_next;
            SEGMENT <= seg_next;
        end
    end

    assign rc_rise = rc_in & ~rc_prev;

    // The edge cycle itself lights the LED, so the counter only needs to cover the remaining cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_prev     <= 1'b0;
            stretch_cnt <= '0;
            rc_led      <= 1'b0;
        end else begin
            rc_prev <= rc_in;
            if (rc_rise) begin
                stretch_cnt <= STRETCH_LOAD;
                rc_led      <= 1'b1;
            end else begin
                if (stretch_cnt != '0) begin
                    stretch_cnt <= stretch_cnt - STRETCH_W'(1);
                end
                rc_led <= (stretch_cnt > STRETCH_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display_16b.sv
// tb/tb_seg7_scan_display_16b.sv - scoreboard bench for seg7_scan_display_16b
module tb_seg7_scan_display_16b;

    localparam int B  = 2;
    localparam int S  = 5;
    localparam int FL = 4 << B;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LEs;
    logic        rc_in;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic        rc_led;

    always #5 clk = ~clk;

    seg7_scan_display_16b #(
        .SCAN_DIV_BITS (B),
        .STRETCH_CYCLES(S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hexs   (hexs),
        .points (points),
        .LEs    (LEs),
        .rc_in  (rc_in),
        .AN     (AN),
        .SEGMENT(SEGMENT),
        .rc_led (rc_led)
    );

    logic [12:0] exp_q[$];
    logic [12:0] got_exp;
    int          checks = 0;
    int          errors = 0;

    logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: position in time since reset decides the digit; the frame is whatever was applied at the last frame end.
    longint      n;
    longint      last_high;
    logic [15:0] f_hex;
    logic [3:0]  f_pts;
    logic [3:0]  f_les;
    logic        prev_rc;

    task automatic drive(input logic r, input logic [15:0] h, input logic [3:0] p,
                         input logic [3:0] l, input logic rc);
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_led;
        int         slot;
        @(negedge clk);
        rst    = r;
        hexs   = h;
        points = p;
        LEs    = l;
        rc_in  = rc;
        if (r) begin
            e_an      = 4'b1111;
            e_seg     = 8'hFF;
            e_led     = 1'b0;
            n         = 0;
            last_high = -1;
            f_hex     = '0;
            f_pts     = '0;
            f_les     = '0;
            prev_rc   = 1'b0;
        end else begin
            slot = int'((n / (1 << B)) % 4);
            if (f_les[slot]) begin
                e_an  = 4'b1111;
                e_seg = 8'hFF;
            end else begin
                e_an  = 4'b1111;
                e_an[slot] = 1'b0;
                e_seg = {~f_pts[slot], font[f_hex[slot*4 +: 4]]};
            end
            if (rc && !prev_rc) last_high = n + S - 1;
            e_led   = (n <= last_high);
            prev_rc = rc;
            if ((n % FL) == FL - 1) begin
                f_hex = h;
                f_pts = p;
                f_les = l;
            end
            n = n + 1;
        end
        exp_q.push_back({e_an, e_seg, e_led});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, hexs, points, LEs, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            got_exp = exp_q.pop_front();
            checks++;
            if ({AN, SEGMENT, rc_led} !== got_exp) begin
                errors++;
                $display("FAIL scan_out t=%0t got AN=%b SEG=%h led=%b want AN=%b SEG=%h led=%b",
                         $time, AN, SEGMENT, rc_led, got_exp[12:9], got_exp[8:1], got_exp[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        r;
        logic [15:0] h;
        logic [3:0]  p;
        logic [3:0]  l;
        logic        rc;
        rst    = 1'b1;
        hexs   = '0;
        points = '0;
        LEs    = '0;
        rc_in  = 1'b0;

        repeat (3) drive(1'b1, 16'h0000, 4'h0, 4'h0, 1'b0);
        repeat (21) drive(1'b0, 16'h1A2F, 4'h0, 4'h0, 1'b0);
        repeat (27) drive(1'b0, 16'h0009, 4'h0, 4'h0, 1'b0);
        repeat (32) drive(1'b0, 16'h1234, 4'b0100, 4'b1000, 1'b0);
        repeat (32) drive(1'b0, 16'hBEEF, 4'b1111, 4'b1111, 1'b0);
        drive(1'b0, 16'h5678, 4'b0011, 4'b0000, 1'b1);
        idle(10);
        drive(1'b0, hexs, points, LEs, 1'b1);
        idle(2);
        drive(1'b0, hexs, points, LEs, 1'b1);
        idle(12);
        repeat (20) drive(1'b0, hexs, points, LEs, 1'b1);
        idle(10);

        drive(1'b1, hexs, points, LEs, 1'b0);
        idle(5);
        drive(1'b0, hexs, points, LEs, 1'b1);
        idle(2);
        drive(1'b1, hexs, points, LEs, 1'b0);
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            h  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : hexs;
            p  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : points;
            l  = ($urandom_range(0, 7) == 0) ? 4'($urandom & $urandom) : LEs;
            rc = ($urandom_range(0, 5) == 0) ? ~rc_in : rc_in;
            drive(r, h, p, l, rc);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
